// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encoding, field widths
// and default bus widths used by both the sequencer and the controller.
package cpu_pkg;

  localparam int PHASE_W    = 3;
  localparam int OPC_W      = 3;
  localparam int DEF_AWIDTH = 5;
  localparam int DEF_DWIDTH = 8;

  typedef enum logic [OPC_W-1:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

endpackage

// File: rtl/ld_counter.sv
// Loadable up-counter with asynchronous active-low clear; load beats increment
// and nothing changes unless enable is high.
module ld_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      if (load) begin
        count_d = load_val;
      end else if (inc) begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/sequence stage: phase counter, instruction register, program counter
// and halt latch, plus the memory address mux feeding the memory.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int AWIDTH = DEF_AWIDTH,
  parameter int DWIDTH = DEF_DWIDTH
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [DWIDTH-1:0]   data_in,
  input  logic                ld_ir,
  input  logic                inc_pc,
  input  logic                ld_pc,
  input  logic                halt,
  input  logic                sel,
  input  logic                run,
  output logic [PHASE_W-1:0]  phase,
  output logic [OPC_W-1:0]    opcode,
  output logic [AWIDTH-1:0]   ir_addr,
  output logic [AWIDTH-1:0]   pc_addr,
  output logic [AWIDTH-1:0]   addr,
  output logic                halted
);

  logic [DWIDTH-1:0] ir_q;
  logic [DWIDTH-1:0] ir_d;
  logic              halted_q;
  logic              halted_d;
  logic              running;

  assign running = !halted_q;

  // Halt latch: run only matters while halted, so halt+run while running halts.
  always_comb begin
    halted_d = halted_q;
    if (halted_q) begin
      if (run) begin
        halted_d = 1'b0;
      end
    end else if (halt) begin
      halted_d = 1'b1;
    end
  end

  always_comb begin
    ir_d = ir_q;
    if (running && ld_ir) begin
      ir_d = data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      halted_q <= halted_d;
    end
  end

  assign opcode  = ir_q[DWIDTH-1 -: OPC_W];
  assign ir_addr = ir_q[AWIDTH-1:0];

  ld_counter #(
    .W (AWIDTH)
  ) u_pc (
    .clk      (clk),
    .rst_     (rst_),
    .enable   (running),
    .load     (ld_pc),
    .load_val (ir_addr),
    .inc      (inc_pc),
    .count    (pc_addr)
  );

  // The phase counter free-runs modulo 8 whenever the machine is not halted.
  ld_counter #(
    .W (PHASE_W)
  ) u_phase (
    .clk      (clk),
    .rst_     (rst_),
    .enable   (running),
    .load     (1'b0),
    .load_val ({PHASE_W{1'b0}}),
    .inc      (1'b1),
    .count    (phase)
  );

  assign addr   = sel ? pc_addr : ir_addr;
  assign halted = halted_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized
// strobes, all compared every cycle against a behavioural machine model.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_;
  logic [7:0] data_in;
  logic       ld_ir, inc_pc, ld_pc, halt, sel, run;
  logic [2:0] phase, opcode;
  logic [4:0] ir_addr, pc_addr, addr;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  int m_phase = 0;
  int m_pc    = 0;
  int m_ir    = 0;
  int m_halt  = 0;

  instr_sequencer #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk     (clk),
    .rst_    (rst_),
    .data_in (data_in),
    .ld_ir   (ld_ir),
    .inc_pc  (inc_pc),
    .ld_pc   (ld_pc),
    .halt    (halt),
    .sel     (sel),
    .run     (run),
    .phase   (phase),
    .opcode  (opcode),
    .ir_addr (ir_addr),
    .pc_addr (pc_addr),
    .addr    (addr),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Machine rules: PC loads the operand held before this edge's IR load.
  always @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      m_phase = 0; m_pc = 0; m_ir = 0; m_halt = 0;
    end else if (m_halt != 0) begin
      if (run) m_halt = 0;
    end else begin
      int operand;
      operand = m_ir % 32;
      if (ld_ir) m_ir = int'(data_in);
      if (ld_pc) m_pc = operand;
      else if (inc_pc) m_pc = (m_pc + 1) % 32;
      if (halt) m_halt = 1;
      m_phase = (m_phase + 1) % 8;
    end
  end

  always @(negedge clk) begin
    check("phase", int'(phase), m_phase);
    check("pc_addr", int'(pc_addr), m_pc);
    check("opcode", int'(opcode), m_ir / 32);
    check("ir_addr", int'(ir_addr), m_ir % 32);
    check("halted", int'(halted), m_halt);
    check("addr", int'(addr), sel ? m_pc : (m_ir % 32));
  end

  task automatic cyc(input bit li, input bit ip, input bit lp, input bit h,
                     input bit s, input bit r, input logic [7:0] d);
    ld_ir = li; inc_pc = ip; ld_pc = lp; halt = h; sel = s; run = r; data_in = d;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 1, 0, 8'h00);
  endtask

  task automatic goto_phase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 8) begin
      idle();
      n++;
    end
    if (m_phase != p) begin
      n_cmp++; n_bad++;
      $display("FAIL goto_phase: got %0d expected %0d", m_phase, p);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph_before;
    rst_ = 1'b0;
    ld_ir = 0; inc_pc = 0; ld_pc = 0; halt = 0; sel = 1; run = 0; data_in = '0;
    repeat (2) @(posedge clk);
    #1 rst_ = 1'b1;

    // Reset state and addr for both sel values
    check("rst_phase", int'(phase), 0);
    check("rst_pc", int'(pc_addr), 0);
    check("rst_opcode", int'(opcode), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_addr_sel1", int'(addr), 0);
    sel = 0; #1;
    check("rst_addr_sel0", int'(addr), 0);

    for (int i = 0; i < 8; i++) begin
      idle();
      check("free_phase", int'(phase), (i + 1) % 8);
    end
    check("free_pc", int'(pc_addr), 0);

    // JMP 9 with the controller strobe pattern
    for (int p = 0; p < 8; p++) begin
      cyc(p == 2 || p == 3, p == 4, p == 6 || p == 7, 0, p < 4, 0, 8'hE9);
      if (p == 3) begin
        check("jmp_opcode", int'(opcode), 7);
        check("jmp_ir_addr", int'(ir_addr), 9);
      end
      if (p == 4) begin
        check("jmp_pc_inc", int'(pc_addr), 1);
        sel = 0; #1;
        check("jmp_addr_sel0", int'(addr), 9);
        sel = 1; #1;
        check("jmp_addr_sel1", int'(addr), 1);
      end
      if (p == 6) begin
        check("jmp_phase7", int'(phase), 7);
        check("jmp_pc_target", int'(pc_addr), 9);
      end
    end

    // PC wrap and ld_pc priority over inc_pc
    cyc(1, 0, 0, 0, 1, 0, 8'h1F);
    cyc(0, 0, 1, 0, 1, 0, 8'h00);
    check("pc_31", int'(pc_addr), 31);
    cyc(0, 1, 0, 0, 1, 0, 8'h00);
    check("pc_wrap", int'(pc_addr), 0);
    cyc(1, 0, 0, 0, 1, 0, 8'h05);
    cyc(0, 1, 1, 0, 1, 0, 8'h00);
    check("ld_beats_inc", int'(pc_addr), 5);

    // HLT at phase 4 with PC=3, frozen while strobes toggle
    cyc(1, 0, 0, 0, 1, 0, 8'h03);
    cyc(0, 0, 1, 0, 1, 0, 8'h00);
    goto_phase(4);
    cyc(0, 1, 0, 1, 1, 0, 8'h00);
    check("hlt_pc", int'(pc_addr), 4);
    check("hlt_halted", int'(halted), 1);
    check("hlt_phase", int'(phase), 5);
    for (int i = 0; i < 10; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0,
          8'($urandom));
    check("frozen_phase", int'(phase), 5);
    check("frozen_pc", int'(pc_addr), 4);
    check("frozen_ir", int'(ir_addr), 3);
    cyc(0, 0, 0, 0, 1, 1, 8'h00);
    check("run_clears", int'(halted), 0);
    check("run_phase_hold", int'(phase), 5);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("resume_phase", int'(phase), (6 + i) % 8);
    end

    // Asynchronous reset in the middle of phase 6 with PC=12
    cyc(1, 0, 0, 0, 1, 0, 8'h0C);
    cyc(0, 0, 1, 0, 1, 0, 8'h00);
    goto_phase(6);
    check("pre_rst_pc", int'(pc_addr), 12);
    #3 rst_ = 1'b0;
    #1;
    check("async_phase", int'(phase), 0);
    check("async_pc", int'(pc_addr), 0);
    check("async_ir", int'(ir_addr), 0);
    @(posedge clk); #1 rst_ = 1'b1;
    check("rel_phase", int'(phase), 0);
    idle();
    check("restart_phase", int'(phase), 1);

    // halt and run together while running: halt wins
    cyc(0, 0, 0, 1, 1, 1, 8'h00);
    check("halt_run_halted", int'(halted), 1);
    ph_before = int'(phase);
    cyc(0, 0, 0, 0, 1, 1, 8'h00);
    check("run_exit", int'(halted), 0);
    check("run_exit_phase", int'(phase), ph_before);
    cyc(0, 0, 0, 0, 1, 1, 8'h00);
    check("run_while_running", int'(halted), 0);
    check("run_while_phase", int'(phase), (ph_before + 1) % 8);

    // Randomized strobes with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
          $urandom_range(0, 19) == 0, 1'($urandom), $urandom_range(0, 9) < 2,
          8'($urandom));
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 7)) rst_ = 1'b0;
        @(posedge clk); #1 rst_ = 1'b1;
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
